// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the 16-point FFT datapath.
// Provides the frame size, component width, complex bin and power types,
// and the state encoding used by fft_peak_detector.
package fft_pkg;

  localparam int FFT_POINTS = 16;
  localparam int FFT_W      = 16;

  // One complex FFT output bin; re occupies the upper half when packed.
  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cbin_t;

  // Squared magnitude of a bin, unsigned.
  typedef logic [2*FFT_W-1:0] power_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/fft_peak_detector_bin_power.sv
// bin_power: squared magnitude re*re + im*im of one complex bin.
// Ports: bin (2W, {re, im} signed), power (2W, unsigned).
// Purely combinational. The largest result is 2^(2W-1), so 2W bits never overflow.
module bin_power #(
  parameter int W = 16
) (
  input  logic [2*W-1:0] bin,
  output logic [2*W-1:0] power
);

  logic signed [W-1:0]   re;
  logic signed [W-1:0]   im;
  logic signed [2*W-1:0] re_x;
  logic signed [2*W-1:0] im_x;
  logic signed [2*W-1:0] rr;
  logic signed [2*W-1:0] ii;

  assign re   = bin[2*W-1:W];
  assign im   = bin[W-1:0];
  assign re_x = {{W{re[W-1]}}, re};
  assign im_x = {{W{im[W-1]}}, im};
  assign rr   = re_x * re_x;
  assign ii   = im_x * im_x;

  // Each square is at most 2^(2W-2), non-negative, so the unsigned sum is exact.
  assign power = $unsigned(rr) + $unsigned(ii);

endmodule

// File: rtl/fft_peak_detector.sv
// fft_peak_detector: captures a 16-bin FFT frame, scans LANES bins per cycle
// for the largest squared magnitude and reports its index and power.
// Ports: clk, rst (async, active-high); fft_valid + fft_d0..fft_d15 frame in;
// done level in; peak_bin/peak_power/peak_valid result; overrun pulse;
// analysis_done sticky flag.
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter int W     = 16,
  parameter int LANES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fft_valid,
  input  logic [2*W-1:0] fft_d0,
  input  logic [2*W-1:0] fft_d1,
  input  logic [2*W-1:0] fft_d2,
  input  logic [2*W-1:0] fft_d3,
  input  logic [2*W-1:0] fft_d4,
  input  logic [2*W-1:0] fft_d5,
  input  logic [2*W-1:0] fft_d6,
  input  logic [2*W-1:0] fft_d7,
  input  logic [2*W-1:0] fft_d8,
  input  logic [2*W-1:0] fft_d9,
  input  logic [2*W-1:0] fft_d10,
  input  logic [2*W-1:0] fft_d11,
  input  logic [2*W-1:0] fft_d12,
  input  logic [2*W-1:0] fft_d13,
  input  logic [2*W-1:0] fft_d14,
  input  logic [2*W-1:0] fft_d15,
  input  logic           done,
  output logic [3:0]     peak_bin,
  output logic [2*W-1:0] peak_power,
  output logic           peak_valid,
  output logic           overrun,
  output logic           analysis_done
);

  localparam int         GROUPS = FFT_POINTS / LANES;
  localparam logic [3:0] LAST_G = 4'(GROUPS - 1);

  state_t         state;
  state_t         state_nxt;
  logic           capture;
  logic           done_flag;
  logic [3:0]     g;
  logic [2*W-1:0] din   [FFT_POINTS];
  logic [2*W-1:0] frame [FFT_POINTS];
  logic [2*W-1:0] lane_dat [LANES];
  logic [2*W-1:0] lane_pw  [LANES];
  logic [2*W-1:0] max_p;
  logic [3:0]     max_b;
  logic [2*W-1:0] best_p;
  logic [3:0]     best_b;

  assign din[0]  = fft_d0;
  assign din[1]  = fft_d1;
  assign din[2]  = fft_d2;
  assign din[3]  = fft_d3;
  assign din[4]  = fft_d4;
  assign din[5]  = fft_d5;
  assign din[6]  = fft_d6;
  assign din[7]  = fft_d7;
  assign din[8]  = fft_d8;
  assign din[9]  = fft_d9;
  assign din[10] = fft_d10;
  assign din[11] = fft_d11;
  assign din[12] = fft_d12;
  assign din[13] = fft_d13;
  assign din[14] = fft_d14;
  assign din[15] = fft_d15;

  // Select the current group of bins for the power units.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_dat[l] = frame[4'(int'(g) * LANES + l)];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bin_power #(.W(W)) u_bin_power (
      .bin   (lane_dat[l]),
      .power (lane_pw[l])
    );
  end

  // Ascending scan with strict greater-than: on ties the lowest index is kept,
  // and the zero-initialised running max makes an all-zero frame report bin 0.
  always_comb begin
    best_p = max_p;
    best_b = max_b;
    for (int l = 0; l < LANES; l++) begin
      if (lane_pw[l] > best_p) begin
        best_p = lane_pw[l];
        best_b = 4'(int'(g) * LANES + l);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (fft_valid) begin
          capture   = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (g == LAST_G) state_nxt = RESULT;
      end
      RESULT: begin
        // The result is already on the outputs; a new frame may start here.
        if (fft_valid) begin
          capture   = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FFT_POINTS; i++) frame[i] <= '0;
      g             <= '0;
      max_p         <= '0;
      max_b         <= '0;
      peak_bin      <= '0;
      peak_power    <= '0;
      peak_valid    <= 1'b0;
      overrun       <= 1'b0;
      done_flag     <= 1'b0;
      analysis_done <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      overrun    <= (state == CALC) && fft_valid;
      done_flag  <= done;
      if (capture) begin
        for (int i = 0; i < FFT_POINTS; i++) frame[i] <= din[i];
        g     <= '0;
        max_p <= '0;
        max_b <= '0;
      end else if (state == CALC) begin
        max_p <= best_p;
        max_b <= best_b;
        g     <= g + 4'd1;
        // Publish on the last group edge so peak_valid is high during RESULT.
        if (g == LAST_G) begin
          peak_bin   <= best_b;
          peak_power <= best_p;
          peak_valid <= 1'b1;
        end
      end
      if (done_flag && (state == IDLE) && !capture) analysis_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_peak_detector.sv
// tb_fft_peak_detector: scoreboard bench for fft_peak_detector (W=16, LANES=4).
// Expected peaks are queued when a frame is driven and checked, including the
// cycle of arrival, when peak_valid is seen; directed and random frames.
module tb_fft_peak_detector;
  import fft_pkg::*;

  localparam int LANES = 4;
  localparam int LAT   = FFT_POINTS / LANES;

  typedef struct {
    logic [3:0]  b;
    logic [31:0] p;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fft_valid;
  logic        done;
  logic [31:0] d  [16];
  logic [31:0] fr [16];
  logic [3:0]  peak_bin;
  logic [31:0] peak_power;
  logic        peak_valid;
  logic        overrun;
  logic        analysis_done;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   peak_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_peak_detector #(.W(16), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done), .peak_bin(peak_bin), .peak_power(peak_power),
    .peak_valid(peak_valid), .overrun(overrun), .analysis_done(analysis_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every peak_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && peak_valid) begin
      peak_cnt++;
      if (sb.size() == 0) begin
        check_eq("unexpected_peak_valid", 64'(peak_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("peak_bin", 64'(peak_bin), 64'(e.b));
        check_eq("peak_power", 64'(peak_power), 64'(e.p));
        check_eq("peak_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [35:0] model_peak();
    logic [3:0]  bb;
    logic [31:0] bp;
    bb = '0;
    bp = '0;
    for (int i = 0; i < 16; i++) begin
      logic signed [15:0] re;
      logic signed [15:0] im;
      longint p;
      re = fr[i][31:16];
      im = fr[i][15:0];
      p  = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      if (p > longint'(bp)) begin
        bp = 32'(p);
        bb = 4'(i);
      end
    end
    return {bb, bp};
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < 16; i++) fr[i] = '0;
  endtask

  // mode 0: accepted, result expected; 1: rejected (overrun);
  // 2: accepted but killed by reset. Called just after a negedge; returns
  // at the negedge following the sampling edge.
  task automatic send(input int mode, input logic [3:0] eb, input logic [31:0] ep);
    exp_t e;
    for (int i = 0; i < 16; i++) d[i] = fr[i];
    fft_valid = 1'b1;
    if (mode == 0) begin
      e.b = eb;
      e.p = ep;
      e.cyc = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    fft_valid = 1'b0;
    for (int i = 0; i < 16; i++) d[i] = $urandom();
    check_eq(mode == 1 ? "overrun_pulse" : "overrun_idle", 64'(overrun), mode == 1 ? 64'd1 : 64'd0);
  endtask

  task automatic send_model();
    logic [35:0] m;
    m = model_peak();
    send(0, m[35:32], m[31:0]);
  endtask

  initial begin
    int pc;
    rst = 1'b1;
    fft_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 16; i++) d[i] = '0;
    clear_frame();
    repeat (3) @(negedge clk);
    check_eq("rst_peak_bin", 64'(peak_bin), 64'd0);
    check_eq("rst_peak_power", 64'(peak_power), 64'd0);
    check_eq("rst_peak_valid", 64'(peak_valid), 64'd0);
    check_eq("rst_overrun", 64'(overrun), 64'd0);
    check_eq("rst_analysis_done", 64'(analysis_done), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single tone at bin 5.
    clear_frame();
    fr[5] = {16'sd1000, 16'sd0};
    send(0, 4'd5, 32'd1000000);
    repeat (8) @(negedge clk);

    // Tie between bins 3 and 12: lowest index wins.
    clear_frame();
    fr[3]  = {16'sd300, -16'sd400};
    fr[12] = {16'sd300, -16'sd400};
    send(0, 4'd3, 32'd250000);
    repeat (8) @(negedge clk);

    // Most negative components give the largest possible power.
    clear_frame();
    fr[15] = {16'h8000, 16'h8000};
    send(0, 4'd15, 32'h8000_0000);
    repeat (8) @(negedge clk);

    // All-zero frame reports bin 0, power 0.
    clear_frame();
    send(0, 4'd0, 32'd0);
    repeat (8) @(negedge clk);

    // Back-to-back frames 6 cycles apart.
    clear_frame();
    fr[2] = {16'sd500, 16'sd0};
    send(0, 4'd2, 32'd250000);
    repeat (5) @(negedge clk);
    clear_frame();
    fr[9] = {16'sd0, -16'sd700};
    send(0, 4'd9, 32'd490000);
    repeat (8) @(negedge clk);

    // Overrun: second frame 2 cycles after the first is dropped.
    pc = peak_cnt;
    clear_frame();
    fr[7] = {16'sd100, 16'sd100};
    send(0, 4'd7, 32'd20000);
    @(negedge clk);
    clear_frame();
    fr[1] = {16'sd2000, 16'sd2000};
    send(1, 4'd0, 32'd0);
    repeat (8) @(negedge clk);
    check_eq("overrun_single_peak", 64'(peak_cnt - pc), 64'd1);

    // done rising mid-frame: analysis_done only after that frame's result.
    pc = peak_cnt;
    clear_frame();
    fr[11] = {-16'sd1234, 16'sd77};
    send(0, 4'd11, 32'd1528685);
    done = 1'b1;
    for (int k = 0; k < 20 && peak_cnt == pc; k++) begin
      check_eq("analysis_done_early", 64'(analysis_done), 64'd0);
      @(negedge clk);
    end
    check_eq("done_frame_peak_seen", 64'(peak_cnt - pc), 64'd1);
    repeat (4) @(negedge clk);
    check_eq("analysis_done_set", 64'(analysis_done), 64'd1);
    done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("analysis_done_sticky", 64'(analysis_done), 64'd1);

    // Reset two cycles after fft_valid, during CALC.
    pc = peak_cnt;
    clear_frame();
    fr[4] = {16'sd50, 16'sd50};
    send(2, 4'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_peak_bin", 64'(peak_bin), 64'd0);
    check_eq("midrst_peak_power", 64'(peak_power), 64'd0);
    check_eq("midrst_analysis_done", 64'(analysis_done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("midrst_no_peak", 64'(peak_cnt - pc), 64'd0);
    clear_frame();
    fr[13] = {16'sd3, -16'sd4};
    send(0, 4'd13, 32'd25);
    repeat (8) @(negedge clk);

    // Random frames with small magnitudes to provoke ties, spacing 5..8 cycles.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 16; i++) begin
        if (f < 4) fr[i] = {16'($urandom_range(0, 3) * 100), 16'($urandom_range(0, 3) * 100)};
        else       fr[i] = $urandom();
      end
      send_model();
      repeat ($urandom_range(4, 7)) @(negedge clk);
    end

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    check_eq("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_peak_detector.md
# fft_peak_detector

Consumer at the output side of the 16-point FFT core. It captures one frame of 16 complex bins on each `fft_valid` pulse and computes the squared magnitude of every bin. It reports the index and power of the strongest bin. It also flags a sticky `analysis_done` once the FFT core signals `done` and no frame remains in flight.

## Interface
Parameters:
- `W`, 16: width of each real/imag component (signed two's complement).
- `LANES`, 4: bins evaluated per cycle; must divide 16 (legal values 1, 2, 4, 8, 16).

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `fft_valid`, in, 1: one-cycle pulse; `fft_d0`..`fft_d15` are valid in that cycle.
- `fft_d0`..`fft_d15`, in, 2W each: bin k = {real[2W-1:W], imag[W-1:0]}.
- `done`, in, 1: level from the FFT core; last frame has been emitted.
- `peak_bin`, out, 4: index of the strongest bin.
- `peak_power`, out, 2W: real²+imag² of that bin, unsigned.
- `peak_valid`, out, 1: one-cycle pulse; `peak_bin` and `peak_power` are valid.
- `overrun`, out, 1: one-cycle pulse; a frame was dropped because the block was busy.
- `analysis_done`, out, 1: sticky; cleared only by reset.

## Operation
- FSM states: IDLE, CALC, RESULT.
  - IDLE: on `fft_valid`, capture all 16 bins into a frame register, clear the running max, set group counter g=0, go to CALC.
  - CALC: one group per cycle. Bins g·LANES .. g·LANES+LANES-1 each go through a squared-magnitude unit. Compare them against each other and against the running max.
    - On the last group (g = 16/LANES-1), go to RESULT. Otherwise increment g.
  - RESULT: register the final max to the outputs and pulse `peak_valid`.
    - If `fft_valid` is high in this cycle, capture the new frame and go to CALC.
    - Otherwise go to IDLE.
- `fft_valid` in CALC: the frame is ignored, `overrun` pulses next cycle, and the in-flight frame completes unaffected.
- Power arithmetic:
  - p = re·re + im·im, with signed W×W products.
  - Maximum is 2·(2^(W-1))² = 2^(2W-1), which fits 2W bits unsigned with no saturation.
  - Example: re=im=-32768 gives 0x80000000.
- Comparison is strictly greater-than, in ascending bin order. On ties the lowest index wins, including an all-zero frame, which reports bin 0 with power 0.
- `done` handling:
  - `done` is sampled each cycle into a flag.
  - `analysis_done` sets in the first cycle the flag is set, the state is IDLE, and no capture is pending.
  - If `done` rises mid-frame, `analysis_done` waits until that frame's `peak_valid` has been issued.
- Reset, including mid-CALC or mid-RESULT:
  - State returns to IDLE; the frame register, counter and running max are discarded.
  - All outputs go to 0: `peak_bin`=0, `peak_power`=0, `peak_valid`=0, `overrun`=0, `analysis_done`=0.
  - No `peak_valid` is issued for the interrupted frame.

## Timing
- `fft_valid` sampled at edge E0 → CALC for cycles E0..E(16/LANES) → `peak_valid` high from E(16/LANES) to E(16/LANES+1).
  - With LANES=4, latency is 5 cycles.
- `peak_bin` and `peak_power` hold their values until the next `peak_valid`.
- Sustained throughput is one frame per 16/LANES+1 cycles; the FFT core's minimum frame spacing of 6 cycles is met with LANES=4.
- `overrun` is asserted exactly one cycle after the rejected `fft_valid`.
- Inputs `fft_d*` are only required to be stable in the `fft_valid` cycle.

## Structure
- Shared package `fft_pkg`:
  - constant `FFT_POINTS`=16
  - constant `FFT_W`=16
  - typedef for a complex bin {re, im}
  - typedef for a power value (2·FFT_W bits)
  - enum for the IDLE/CALC/RESULT states
- Sub-module `bin_power`: combinational, 2W-bit complex in → 2W-bit unsigned power out; instantiated LANES times.
- Top level holds the frame register, group counter, FSM, compare tree, output registers and done logic.

## Test plan
- Single tone: bin 5 = {re 1000, im 0}, all other bins 0 → `peak_valid` 5 cycles after `fft_valid`; `peak_bin`=5, `peak_power`=1000000.
- Tie and extreme value:
  - bins 3 and 12 = {re 300, im -400}, rest 0 → `peak_bin`=3, `peak_power`=250000.
  - separate frame with bin 15 = {-32768, -32768} → `peak_bin`=15, `peak_power`=0x80000000.
- Back-to-back: two frames with `fft_valid` 6 cycles apart, peaks at bins 2 and 9 → two `peak_valid` pulses 6 cycles apart reporting 2 then 9; `overrun` stays 0.
- Overrun: second `fft_valid` 2 cycles after the first → `overrun` pulses once; exactly one `peak_valid` is issued, carrying the first frame's result.
- Done: `done` rises while a frame is in CALC → `analysis_done` goes to 1 only after that frame's `peak_valid`, then stays high.
- Reset mid-CALC: assert `rst` 2 cycles after `fft_valid` → all outputs are 0 immediately; no `peak_valid` follows; the next frame is processed normally.
